// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Load/store controller that sits between a pipeline and a
//               combinational-read data memory. It accepts one request at a
//               time, stalls the pipeline for WAIT_STATES memory cycles and
//               then returns a one-cycle completion pulse. Out-of-range
//               requests complete in one cycle with resp_err set and never
//               touch the memory.
// Ports       : clk, rst (sync, active-low)
//               req_valid/req_write/req_addr/req_wdata -> req_ready
//               resp_valid/resp_rdata/resp_err, freeze (pipeline stall)
//               Address/Write_data/MEM_R_EN/MEM_W_EN -> memory, Data <- memory
// Config      : `define MEM_ACCESS_ALIGN_CHECK_EN to reject addresses whose
//               low two bits are non-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int WAIT_STATES = 2,
    parameter int BASE_ADDR   = 1024,
    parameter int MEM_DEPTH   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        freeze,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    output logic        MEM_R_EN,
    output logic        MEM_W_EN,
    input  logic [31:0] Data
);

    localparam logic [31:0] c_base_addr = 32'(BASE_ADDR);
    localparam logic [31:0] c_mem_depth = 32'(MEM_DEPTH);
    localparam logic [3:0]  c_wait_init = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        resp_valid_q;
    logic        resp_err_q;

    logic [31:0] w_offset;
    logic [31:0] w_index;
    logic        w_illegal;

    // Whole-vector shift keeps the byte-offset bits in the expression even
    // when alignment is not checked; they simply fall off the bottom.
    assign w_offset = req_addr - c_base_addr;
    assign w_index  = w_offset >> 2;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign w_illegal = (req_addr < c_base_addr) || (w_index >= c_mem_depth) ||
                       (req_addr[1:0] != 2'b00);
`else
    assign w_illegal = (req_addr < c_base_addr) || (w_index >= c_mem_depth);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            rdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            // Completion flags are single-cycle; only the RESP entry sets them.
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= w_index;
                        wdata_q <= req_wdata;
                        if (w_illegal) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            if (!req_write) begin
                                rdata_q <= 32'd0;
                            end
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= c_wait_init;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        if (!write_q) begin
                            rdata_q <= Data;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign freeze     = ((state_q == S_IDLE) && req_valid) || (state_q == S_WAIT);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = rdata_q;
    assign Address    = addr_q;
    assign Write_data = wdata_q;

    // Enables are gated by rst directly so a reset asserted mid-access
    // suppresses the write on that very edge, not one cycle later.
    assign MEM_R_EN = rst && (state_q == S_WAIT) && !write_q;
    assign MEM_W_EN = rst && (state_q == S_WAIT) && write_q && (cnt_q == 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Scoreboard bench for mem_access_ctrl with a behavioural
//               data memory. Stimulus pushes expected responses; a negedge
//               monitor pops and compares on every resp_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        freeze;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] Data;

    mem_access_ctrl #(
        .WAIT_STATES(WS),
        .BASE_ADDR  (1024),
        .MEM_DEPTH  (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .freeze    (freeze),
        .Address   (Address),
        .Write_data(Write_data),
        .MEM_R_EN  (MEM_R_EN),
        .MEM_W_EN  (MEM_W_EN),
        .Data      (Data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural data memory
    logic [31:0] mem [64];
    initial for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    always @(posedge clk) if (MEM_W_EN && Address < 64) mem[Address[5:0]] <= Write_data;
    assign Data = (Address < 64) ? mem[Address[5:0]] : 32'hDEADBEEF;

    typedef struct {
        int          issue;
        int          lat;
        bit          err;
        bit          chk_rd;
        logic [31:0] rdata;
        logic [31:0] addr;
        int          wcnt;
        int          rcnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   wcnt = 0;
    int   rcnt = 0;
    int   wcyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t ex(input int lat, input bit err, input bit chk,
                                input logic [31:0] rd, input logic [31:0] addr,
                                input int wc, input int rc);
        exp_t e;
        e.issue = 0; e.lat = lat; e.err = err; e.chk_rd = chk;
        e.rdata = rd; e.addr = addr; e.wcnt = wc; e.rcnt = rc;
        return e;
    endfunction

    // Monitor: enable counting and response checking
    exp_t m;
    always @(negedge clk) begin
        if (MEM_W_EN) begin wcnt++; wcyc = cyc; end
        if (MEM_R_EN) rcnt++;
        if (MEM_R_EN || MEM_W_EN) check("freeze_in_wait", 32'(freeze), 32'd1);
        if (resp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                m = sb.pop_front();
                check("latency",  32'(cyc - m.issue), 32'(m.lat));
                check("resp_err", 32'(resp_err), 32'(m.err));
                check("address",  Address, m.addr);
                check("wen_cnt",  32'(wcnt), 32'(m.wcnt));
                check("ren_cnt",  32'(rcnt), 32'(m.rcnt));
                if (m.wcnt == 1) check("wen_cycle", 32'(wcyc - m.issue), 32'(WS));
                if (m.chk_rd)    check("rdata", resp_rdata, m.rdata);
                check("resp_ready", 32'(req_ready), 32'd0);
            end
            wcnt = 0;
            rcnt = 0;
        end
    end

    // Called at a negedge; holds the request until accepted, returns at posedge+1.
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input exp_t e);
        bit acc = 0;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        for (int k = 0; k < 20; k++) begin
            #1;
            check("freeze_req", 32'(freeze), 32'(req_ready));
            if (req_ready) begin
                e.issue = cyc;
                sb.push_back(e);
                acc = 1;
                @(posedge clk); #1;
                break;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 40; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            check("resp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic step(input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input exp_t e);
        @(negedge clk);
        issue(wr, addr, wdata, e);
        wait_done();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready",  32'(req_ready), 32'd1);
        check("rst_valid",  32'(resp_valid), 32'd0);
        check("rst_rdata",  resp_rdata, 32'd0);
        check("rst_addr",   Address, 32'd0);
        check("rst_wdata",  Write_data, 32'd0);
        check("rst_en",     32'({MEM_R_EN, MEM_W_EN}), 32'd0);
        rst = 1'b1;

        // store 0xFF to 1032 -> index 2, write in the last WAIT cycle
        step(1'b1, 32'd1032, 32'h000000FF, ex(WS + 1, 1'b0, 1'b0, 32'd0, 32'd2, 1, 0));
        // load it back
        step(1'b0, 32'd1032, 32'd0, ex(WS + 1, 1'b0, 1'b1, 32'h000000FF, 32'd2, 0, WS));
        // below base: illegal load clears rdata
        step(1'b0, 32'd1000, 32'd0, ex(1, 1'b1, 1'b1, 32'd0, 32'h3FFFFFFA, 0, 0));
        // index 64: one past the end
        step(1'b1, 32'd1280, 32'h11111111, ex(1, 1'b1, 1'b0, 32'd0, 32'd64, 0, 0));
        // word 0 then unaligned load of it
        step(1'b1, 32'd1024, 32'h12345678, ex(WS + 1, 1'b0, 1'b0, 32'd0, 32'd0, 1, 0));
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        step(1'b0, 32'd1026, 32'd0, ex(1, 1'b1, 1'b1, 32'd0, 32'd0, 0, 0));
`else
        step(1'b0, 32'd1026, 32'd0, ex(WS + 1, 1'b0, 1'b1, 32'h12345678, 32'd0, 0, WS));
`endif
        // last legal word
        step(1'b1, 32'd1276, 32'hCAFEF00D, ex(WS + 1, 1'b0, 1'b0, 32'd0, 32'd63, 1, 0));
        step(1'b0, 32'd1276, 32'd0, ex(WS + 1, 1'b0, 1'b1, 32'hCAFEF00D, 32'd63, 0, WS));

        // request presented during RESP is taken on the following IDLE edge
        @(negedge clk);
        issue(1'b0, 32'd1032, 32'd0, ex(WS + 1, 1'b0, 1'b1, 32'h000000FF, 32'd2, 0, WS));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        issue(1'b0, 32'd1024, 32'd0, ex(WS + 1, 1'b0, 1'b1, 32'h12345678, 32'd0, 0, WS));
        wait_done();

        // reset during the write cycle of a store to index 1
        @(negedge clk);
        issue(1'b1, 32'd1028, 32'hA5A5A5A5, ex(WS + 1, 1'b0, 1'b0, 32'd0, 32'd1, 1, 0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_wen_gate", 32'(MEM_W_EN), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_rdata", resp_rdata, 32'd0);
        check("post_rst_addr",  Address, 32'd0);
        check("post_rst_wcnt",  32'(wcnt), 32'd0);
        check("post_rst_mem1",  mem[1], 32'd0);
        repeat (4) @(negedge clk);
        check("post_rst_noresp_wcnt", 32'(wcnt), 32'd0);
        wcnt = 0;
        rcnt = 0;

        // normal operation after reset
        step(1'b0, 32'd1032, 32'd0, ex(WS + 1, 1'b0, 1'b1, 32'h000000FF, 32'd2, 0, WS));

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
